// File: rtl/exe_pkg.sv
// Shared types and encodings for the execute stage and its iterative multiply/divide unit.
package exe_pkg;

    typedef enum logic [2:0] {
        AluAdd    = 3'd0,
        AluRtype  = 3'd1,
        AluItype  = 3'd2,
        AluLui    = 3'd3,
        AluBranch = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        BrNone = 2'b00,
        BrCond = 2'b01,
        BrJal  = 2'b10,
        BrJalr = 2'b11
    } branch_e;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdCalc = 2'd1,
        MdDone = 2'd2
    } md_state_e;

    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative RV32M unit: one bit per cycle, shift-add multiply and restoring divide on magnitudes,
// with sign correction applied to the presented result.
module mul_div_iter
    import exe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ack,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);

    md_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   hi_q, lo_q, a_q, b_q;
    logic [2:0]        f3_q;
    logic              neg_q, rneg_q, dz_q;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, addend, hi_d, lo_d, quo, rem;
    logic [XLEN:0]     mul_sum, rem_shift;
    logic [2*XLEN-1:0] prod;

    assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_neg    = a_signed & op_a[XLEN-1];
    assign b_neg    = b_signed & op_b[XLEN-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;

    assign busy = (state_q == MdCalc) || ((state_q == MdIdle) && start);
    assign done = (state_q == MdDone);

    // hi holds the partial product / running remainder, lo the multiplier / quotient bits
    always_comb begin
        addend    = lo_q[0] ? b_q : '0;
        mul_sum   = {1'b0, hi_q} + {1'b0, addend};
        rem_shift = {hi_q, lo_q[XLEN-1]};
        if (f3_q[2]) begin
            if (rem_shift >= {1'b0, b_q}) begin
                hi_d = rem_shift[XLEN-1:0] - b_q;
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = rem_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                MdIdle: begin
                    if (start) begin
                        f3_q    <= funct3;
                        a_q     <= op_a;
                        b_q     <= b_mag;
                        hi_q    <= '0;
                        lo_q    <= a_mag;
                        neg_q   <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        dz_q    <= (op_b == '0);
                        cnt_q   <= CW'(XLEN - 1);
                        state_q <= MdCalc;
                    end
                end
                MdCalc: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= MdDone;
                end
                MdDone: if (ack) state_q <= MdIdle;
                default: state_q <= MdIdle;
            endcase
        end
    end

    always_comb begin
        prod = {hi_q, lo_q};
        if (neg_q) prod = -prod;
        quo = neg_q ? -lo_q : lo_q;
        rem = rneg_q ? -hi_q : hi_q;
        case (f3_q)
            F3_MUL:                      result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             result = dz_q ? '1 : quo;
            default:                     result = dz_q ? a_q : rem;
        endcase
    end

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage: forwarding, ALU, branch resolution with redirect, iterative M-ops and the
// EXE/MEM pipeline register with stall/bubble handling.
module exe_stage_md
    import exe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter bit          MD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1,
    input  logic [XLEN-1:0] id_rs2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  alu_op_e         id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_pc_to_reg_src,
    input  logic [1:0]      id_branch,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_mem_to_reg,
    input  logic            id_rd_src,
    input  logic            fwd_mem_we,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic            mem_ready,
    output logic            stall_out,
    output logic            flush_out,
    output logic [XLEN-1:0] redirect_pc,
    output logic            exe_valid,
    output logic            exe_reg_write,
    output logic            exe_mem_read,
    output logic            exe_mem_write,
    output logic            exe_mem_to_reg,
    output logic            exe_rd_src,
    output logic [XLEN-1:0] exe_alu_out,
    output logic [XLEN-1:0] exe_pc_to_reg,
    output logic [XLEN-1:0] exe_rs2_data,
    output logic [4:0]      exe_rd_addr,
    output logic [2:0]      exe_funct3
);

    localparam int unsigned SW = $clog2(XLEN);

    logic [XLEN-1:0] rs1_fwd, rs2_fwd, op2, add_res, sub_res, alu_res, md_result, target;
    logic [SW-1:0]   shamt;
    logic            is_mop, md_start, md_busy, md_done, advance, cond, taken;

    always_comb begin
        rs1_fwd = id_rs1;
        if (fwd_wb_we && (fwd_wb_rd != '0) && (fwd_wb_rd == id_rs1_addr)) rs1_fwd = fwd_wb_data;
        if (fwd_mem_we && (fwd_mem_rd != '0) && (fwd_mem_rd == id_rs1_addr)) rs1_fwd = fwd_mem_data;
        rs2_fwd = id_rs2;
        if (fwd_wb_we && (fwd_wb_rd != '0) && (fwd_wb_rd == id_rs2_addr)) rs2_fwd = fwd_wb_data;
        if (fwd_mem_we && (fwd_mem_rd != '0) && (fwd_mem_rd == id_rs2_addr)) rs2_fwd = fwd_mem_data;
    end

    assign op2     = id_alu_src ? id_imm : rs2_fwd;
    assign add_res = rs1_fwd + op2;
    assign sub_res = rs1_fwd - op2;
    assign shamt   = op2[SW-1:0];

    always_comb begin
        alu_res = add_res;
        case (id_alu_op)
            AluLui: alu_res = op2;
            AluRtype, AluItype: begin
                case (id_funct3)
                    F3_ADD:  alu_res = ((id_alu_op == AluRtype) && (id_funct7 == F7_ALT)) ?
                                       sub_res : add_res;
                    F3_SLL:  alu_res = rs1_fwd << shamt;
                    F3_SLT:  alu_res = XLEN'($signed(rs1_fwd) < $signed(op2));
                    F3_SLTU: alu_res = XLEN'(rs1_fwd < op2);
                    F3_XOR:  alu_res = rs1_fwd ^ op2;
                    F3_SR:   alu_res = id_funct7[5] ? $unsigned($signed(rs1_fwd) >>> shamt) :
                                                      rs1_fwd >> shamt;
                    F3_OR:   alu_res = rs1_fwd | op2;
                    default: alu_res = rs1_fwd & op2;
                endcase
            end
            default: alu_res = add_res;
        endcase
    end

    always_comb begin
        case (id_funct3)
            F3_BEQ:  cond = (rs1_fwd == rs2_fwd);
            F3_BNE:  cond = (rs1_fwd != rs2_fwd);
            F3_BLT:  cond = ($signed(rs1_fwd) < $signed(rs2_fwd));
            F3_BGE:  cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            F3_BLTU: cond = (rs1_fwd < rs2_fwd);
            F3_BGEU: cond = (rs1_fwd >= rs2_fwd);
            default: cond = 1'b0;
        endcase
        taken  = ((id_branch == BrCond) && cond) || (id_branch == BrJal) || (id_branch == BrJalr);
        target = (id_branch == BrJalr) ? ((rs1_fwd + id_imm) & ~XLEN'(1)) : (id_pc + id_imm);
    end

    assign is_mop   = MD_EN && (id_alu_op == AluRtype) && (id_funct7 == F7_MULDIV);
    assign md_start = id_valid & is_mop;

    mul_div_iter #(
        .XLEN(XLEN)
    ) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .ack    (mem_ready),
        .funct3 (id_funct3),
        .op_a   (rs1_fwd),
        .op_b   (rs2_fwd),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign advance = id_valid & mem_ready & ~md_busy;

    // Combinational outputs are forced low while reset is held
    assign stall_out   = rst & id_valid & (~mem_ready | md_busy);
    assign flush_out   = rst & advance & taken;
    assign redirect_pc = flush_out ? target : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_valid      <= 1'b0;
            exe_reg_write  <= 1'b0;
            exe_mem_read   <= 1'b0;
            exe_mem_write  <= 1'b0;
            exe_mem_to_reg <= 1'b0;
            exe_rd_src     <= 1'b0;
            exe_alu_out    <= '0;
            exe_pc_to_reg  <= '0;
            exe_rs2_data   <= '0;
            exe_rd_addr    <= '0;
            exe_funct3     <= '0;
        end else if (advance) begin
            exe_valid      <= 1'b1;
            exe_reg_write  <= id_reg_write;
            exe_mem_read   <= id_mem_read;
            exe_mem_write  <= id_mem_write;
            exe_mem_to_reg <= id_mem_to_reg;
            exe_rd_src     <= id_rd_src;
            exe_alu_out    <= (is_mop && md_done) ? md_result : alu_res;
            exe_pc_to_reg  <= id_pc_to_reg_src ? (id_pc + XLEN'(4)) : (id_pc + id_imm);
            exe_rs2_data   <= rs2_fwd;
            exe_rd_addr    <= id_rd_addr;
            exe_funct3     <= id_funct3;
        end else if (mem_ready) begin
            exe_valid     <= 1'b0;
            exe_reg_write <= 1'b0;
            exe_mem_read  <= 1'b0;
            exe_mem_write <= 1'b0;
        end
    end

endmodule
